fetch_stage: RTL and testbench

- IF stage that feeds the instruction decoder. It holds SPARC-style PC/nPC, issues single-outstanding requests to instruction memory, and loads the IF/ID pipeline register that drives the decoder's instr input.
- It implements the delayed-branch model: a redirect from ID retargets nPC only, so the delay-slot instruction at PC is always fetched.
- A one-entry hold buffer absorbs a memory response that returns while ID is stalled.

---
 rtl/fetch_pkg.sv | 18 +
 rtl/fetch_hold_buf.sv | 46 ++++
 rtl/fetch_stage.sv | 202 ++++++++++++++++++++
 tb/tb_fetch_stage.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package fetch_pkg;

    // Fetch FSM: ISSUE drives the request, WAIT holds for the response,
    // HOLD parks a response that arrived while ID was stalled.
    typedef enum logic [1:0] {
        ISSUE = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2
    } fetch_state_e;

    // All-zero word decodes as a nop in the decoder.
    localparam logic [31:0] NOP_WORD    = 32'h0000_0000;
    localparam int          INSTR_BYTES = 4;

endpackage

// File: rtl/fetch_hold_buf.sv
// One-entry skid register that parks a fetched word while ID is stalled.
// Latency: 1 cycle from load to vld_o; drain frees the entry at the next edge.
// Backpressure: the owner never loads while full; load wins over drain.
//
// Ports: clk/rst_n (sync active-low), load_i + dat_i capture a word,
//        drain_i empties the entry, vld_o/dat_o present the parked word.
module fetch_hold_buf
    import fetch_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_i,
    input  logic        drain_i,
    input  logic [31:0] dat_i,
    output logic        vld_o,
    output logic [31:0] dat_o
);

    logic        vld_q, vld_d;
    logic [31:0] dat_q, dat_d;

    always_comb begin
        vld_d = vld_q;
        dat_d = dat_q;
        if (load_i) begin
            vld_d = 1'b1;
            dat_d = dat_i;
        end else if (drain_i) begin
            vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_q <= 1'b0;
            dat_q <= NOP_WORD;
        end else begin
            vld_q <= vld_d;
            dat_q <= dat_d;
        end
    end

    assign vld_o = vld_q;
    assign dat_o = dat_q;

endmodule

// File: rtl/fetch_stage.sv
// IF stage: SPARC PC/nPC, single-outstanding imem fetch, IF/ID register.
// Latency: >=2 cycles ISSUE->IF/ID valid (grant + rvalid); 1 instr / 2 cycles.
// Backpressure: LE=0 stalls IF/ID; a response arriving then parks in HOLD.
//
// Ports: clk, rst_n (sync active-low); imem_req/imem_addr/imem_gnt/
//        imem_rvalid/imem_rdata to instruction memory; LE from the hazard
//        unit; redirect/redirect_target/redirect_annul from ID; if_id_* to
//        the decoder.
// Optional build macro FETCH_ANNUL_EN: when defined, redirect_annul squashes
// the delay-slot instruction (delivered as an invalid nop).
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [31:0]       imem_rdata,
    input  logic              LE,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_target,
    input  logic              redirect_annul,
    output logic [31:0]       if_id_instr,
    output logic [ADDR_W-1:0] if_id_pc,
    output logic [ADDR_W-1:0] if_id_npc,
    output logic              if_id_valid
);

    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(INSTR_BYTES);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d, npc_q, npc_d;
    logic [31:0]       instr_q, instr_d;
    logic [ADDR_W-1:0] ifpc_q, ifpc_d, ifnpc_q, ifnpc_d;
    logic              ifvld_q, ifvld_d;
    logic              drop_q, drop_d;

    logic              rvalid_eff;
    logic              deliver;
    logic [31:0]       deliver_word;
    logic              buf_load, buf_drain, buf_vld;
    logic [31:0]       buf_dat;
    logic              squash;

    // A response whose request was issued before a reset belongs to nobody.
    assign rvalid_eff = imem_rvalid && !drop_q;

    // The request is held off while a pre-reset response is still in flight,
    // so at most one response can ever be outstanding.
    assign imem_req  = (state_q == ISSUE) && rst_n && !drop_q;
    assign imem_addr = pc_q;

    fetch_hold_buf u_hold_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (buf_load),
        .drain_i (buf_drain),
        .dat_i   (imem_rdata),
        .vld_o   (buf_vld),
        .dat_o   (buf_dat)
    );

    // Next state and delivery decision.
    always_comb begin
        state_d      = state_q;
        deliver      = 1'b0;
        deliver_word = NOP_WORD;
        buf_load     = 1'b0;
        buf_drain    = 1'b0;
        case (state_q)
            ISSUE: begin
                if (imem_req && imem_gnt) state_d = WAIT;
            end
            WAIT: begin
                if (rvalid_eff) begin
                    if (LE) begin
                        deliver      = 1'b1;
                        deliver_word = imem_rdata;
                        state_d      = ISSUE;
                    end else begin
                        buf_load = 1'b1;
                        state_d  = HOLD;
                    end
                end
            end
            HOLD: begin
                if (LE && buf_vld) begin
                    deliver      = 1'b1;
                    deliver_word = buf_dat;
                    buf_drain    = 1'b1;
                    state_d      = ISSUE;
                end
            end
            default: state_d = ISSUE;
        endcase
    end

    // Drop flag: armed by a reset that lands while a response is owed,
    // cleared by the response itself (even if it arrives during reset).
    always_comb begin
        drop_d = drop_q;
        if (!rst_n) begin
            drop_d = (drop_q || (state_q == WAIT)) && !imem_rvalid;
        end else if (imem_rvalid) begin
            drop_d = 1'b0;
        end
    end

`ifdef FETCH_ANNUL_EN
    logic annul_q, annul_d;

    // The slot is squashed by a pending annul, or by an annulling redirect
    // that coincides with the slot's own delivery.
    assign squash = annul_q || (redirect && redirect_annul);

    always_comb begin
        annul_d = annul_q;
        if (deliver) begin
            annul_d = 1'b0;
        end else if (redirect) begin
            annul_d = redirect_annul;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) annul_q <= 1'b0;
        else        annul_q <= annul_d;
    end
`else
    logic unused_annul;
    assign unused_annul = redirect_annul;
    assign squash       = 1'b0;
`endif

    // PC/nPC: a redirect only retargets nPC, so the delay slot at PC is still
    // fetched. If the slot is delivering in the same cycle, jump directly.
    always_comb begin
        pc_d  = pc_q;
        npc_d = npc_q;
        if (deliver) begin
            if (redirect) begin
                pc_d  = redirect_target;
                npc_d = redirect_target + STEP;
            end else begin
                pc_d  = npc_q;
                npc_d = npc_q + STEP;
            end
        end else if (redirect) begin
            npc_d = redirect_target;
        end
    end

    // IF/ID register: load on delivery, bubble when ID advances with nothing
    // new, otherwise hold for the stalled decoder.
    always_comb begin
        instr_d = instr_q;
        ifpc_d  = ifpc_q;
        ifnpc_d = ifnpc_q;
        ifvld_d = ifvld_q;
        if (deliver) begin
            instr_d = squash ? NOP_WORD : deliver_word;
            ifvld_d = !squash;
            ifpc_d  = pc_q;
            ifnpc_d = npc_q;
        end else if (LE) begin
            instr_d = NOP_WORD;
            ifvld_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ISSUE;
            pc_q    <= RESET_PC;
            npc_q   <= RESET_PC + STEP;
            instr_q <= NOP_WORD;
            ifpc_q  <= '0;
            ifnpc_q <= '0;
            ifvld_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            npc_q   <= npc_d;
            instr_q <= instr_d;
            ifpc_q  <= ifpc_d;
            ifnpc_q <= ifnpc_d;
            ifvld_q <= ifvld_d;
        end
        drop_q <= drop_d;
    end

    assign if_id_instr = instr_q;
    assign if_id_pc    = ifpc_q;
    assign if_id_npc   = ifnpc_q;
    assign if_id_valid = ifvld_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a zero-wait instruction memory model
// that can be overridden cycle by cycle for stall and reset scenarios.
module tb_fetch_stage;

    localparam int          AW  = 32;
    localparam logic [31:0] RPC = 32'h0000_0100;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_gnt = 1'b0;
    logic          imem_rvalid = 1'b0;
    logic [31:0]   imem_rdata = 32'h0;
    logic          LE = 1'b1;
    logic          redirect = 1'b0;
    logic [AW-1:0] redirect_target = '0;
    logic          redirect_annul = 1'b0;
    logic [31:0]   if_id_instr;
    logic [AW-1:0] if_id_pc;
    logic [AW-1:0] if_id_npc;
    logic          if_id_valid;

    int checks = 0;
    int failures = 0;

    // Memory model controls.
    logic        mem_auto = 1'b1;
    logic        man_gnt = 1'b0;
    logic        man_rvalid = 1'b0;
    logic [31:0] man_rdata = 32'h0;
    logic        pend = 1'b0;
    logic [31:0] pend_addr = 32'h0;

    fetch_stage #(.ADDR_W(AW), .RESET_PC(RPC)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_gnt        (imem_gnt),
        .imem_rvalid     (imem_rvalid),
        .imem_rdata      (imem_rdata),
        .LE              (LE),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .redirect_annul  (redirect_annul),
        .if_id_instr     (if_id_instr),
        .if_id_pc        (if_id_pc),
        .if_id_npc       (if_id_npc),
        .if_id_valid     (if_id_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    // Zero-wait memory: grant whenever requested, respond the next cycle.
    always @(posedge clk) begin
        if (!mem_auto || imem_rvalid) pend = 1'b0;
        if (mem_auto && imem_req && imem_gnt) begin
            pend      = 1'b1;
            pend_addr = imem_addr;
        end
    end

    always @(negedge clk) begin
        if (mem_auto) begin
            imem_gnt    = imem_req;
            imem_rvalid = pend;
            imem_rdata  = pend ? word_of(pend_addr) : 32'h0;
        end else begin
            imem_gnt    = man_gnt;
            imem_rvalid = man_rvalid;
            imem_rdata  = man_rdata;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_pc(input logic [31:0] pc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (if_id_pc === pc) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0; LE = 1'b1; redirect = 1'b0; redirect_annul = 1'b0;
        mem_auto = 1'b1; man_gnt = 1'b0; man_rvalid = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        bit ok;
        rst_n = 1'b0;
        repeat (2) tick();
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL rst_req got=%b exp=0", imem_req); end
        checks++; if (imem_addr !== RPC) begin failures++; $display("FAIL rst_addr got=%h exp=%h", imem_addr, RPC); end
        checks++; if (if_id_instr !== 32'h0 || if_id_pc !== 32'h0 || if_id_npc !== 32'h0 || if_id_valid !== 1'b0) begin
            failures++; $display("FAIL rst_ifid got=%h/%h/%h/%b exp=0/0/0/0", if_id_instr, if_id_pc, if_id_npc, if_id_valid);
        end
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            logic [31:0] epc;
            epc = RPC + 32'(4 * k);
            wait_pc(epc, ok);
            checks++; if (!ok || if_id_valid !== 1'b1 || if_id_instr !== word_of(epc)) begin
                failures++; $display("FAIL seq%0d got pc=%h v=%b i=%h exp pc=%h v=1 i=%h", k, if_id_pc, if_id_valid, if_id_instr, epc, word_of(epc));
            end
            checks++; if (if_id_npc !== epc + 32'd4) begin
                failures++; $display("FAIL seq%0d_npc got=%h exp=%h", k, if_id_npc, epc + 32'd4);
            end
        end
    endtask

    task automatic test_redirect();
        bit ok;
        do_reset();
        wait_pc(32'h100, ok);
        redirect = 1'b1; redirect_target = 32'h200;
        tick();
        redirect = 1'b0;
        wait_pc(32'h104, ok);
        checks++; if (!ok || if_id_valid !== 1'b1 || if_id_npc !== 32'h200) begin
            failures++; $display("FAIL redir_slot got pc=%h v=%b npc=%h exp pc=104 v=1 npc=200", if_id_pc, if_id_valid, if_id_npc);
        end
        wait_pc(32'h200, ok);
        checks++; if (!ok || if_id_instr !== word_of(32'h200) || if_id_npc !== 32'h204) begin
            failures++; $display("FAIL redir_tgt got pc=%h i=%h npc=%h exp pc=200 npc=204", if_id_pc, if_id_instr, if_id_npc);
        end
        wait_pc(32'h204, ok);
        checks++; if (!ok || if_id_valid !== 1'b1) begin
            failures++; $display("FAIL redir_next got pc=%h v=%b exp pc=204 v=1", if_id_pc, if_id_valid);
        end
    endtask

    task automatic test_same_cycle_redirect();
        bit ok;
        do_reset();
        wait_pc(32'h100, ok);
        tick();  // response for 0x104 is delivered at the end of this cycle
        redirect = 1'b1; redirect_target = 32'h300;
        tick();
        redirect = 1'b0;
        checks++; if (if_id_pc !== 32'h104 || if_id_npc !== 32'h108 || if_id_valid !== 1'b1) begin
            failures++; $display("FAIL same_slot got pc=%h npc=%h v=%b exp pc=104 npc=108 v=1", if_id_pc, if_id_npc, if_id_valid);
        end
        wait_pc(32'h300, ok);
        checks++; if (!ok || if_id_npc !== 32'h304 || if_id_instr !== word_of(32'h300)) begin
            failures++; $display("FAIL same_tgt got pc=%h npc=%h i=%h exp pc=300 npc=304", if_id_pc, if_id_npc, if_id_instr);
        end
    endtask

    task automatic test_wrap();
        bit ok;
        do_reset();
        wait_pc(32'h100, ok);
        redirect = 1'b1; redirect_target = 32'hFFFF_FFF8;
        tick();
        redirect = 1'b0;
        wait_pc(32'hFFFF_FFFC, ok);
        checks++; if (!ok || if_id_npc !== 32'h0) begin
            failures++; $display("FAIL wrap_top got pc=%h npc=%h exp pc=fffffffc npc=0", if_id_pc, if_id_npc);
        end
        wait_pc(32'h0, ok);
        checks++; if (!ok || if_id_valid !== 1'b1 || if_id_npc !== 32'h4) begin
            failures++; $display("FAIL wrap_zero got pc=%h v=%b npc=%h exp pc=0 v=1 npc=4", if_id_pc, if_id_valid, if_id_npc);
        end
    endtask

    task automatic test_hold();
        bit ok;
        do_reset();
        wait_pc(32'h100, ok);
        LE = 1'b0; mem_auto = 1'b0; man_gnt = 1'b1; man_rvalid = 1'b0;
        tick();
        man_gnt = 1'b0; man_rvalid = 1'b1; man_rdata = 32'hDEAD_BEEF;
        tick();
        man_rvalid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            checks++; if (if_id_instr !== word_of(32'h100) || if_id_valid !== 1'b1 || if_id_pc !== 32'h100) begin
                failures++; $display("FAIL hold_keep%0d got i=%h v=%b pc=%h exp i=%h v=1 pc=100", k, if_id_instr, if_id_valid, if_id_pc, word_of(32'h100));
            end
            checks++; if (imem_req !== 1'b0) begin
                failures++; $display("FAIL hold_req%0d got=%b exp=0", k, imem_req);
            end
            tick();
        end
        checks++; if (imem_req !== 1'b0 || if_id_instr !== word_of(32'h100)) begin
            failures++; $display("FAIL hold_last got req=%b i=%h exp req=0 i=%h", imem_req, if_id_instr, word_of(32'h100));
        end
        LE = 1'b1;
        tick();
        checks++; if (if_id_instr !== 32'hDEAD_BEEF || if_id_pc !== 32'h104 || if_id_npc !== 32'h108 || if_id_valid !== 1'b1) begin
            failures++; $display("FAIL hold_load got i=%h pc=%h npc=%h v=%b exp i=deadbeef pc=104 npc=108 v=1", if_id_instr, if_id_pc, if_id_npc, if_id_valid);
        end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h108) begin
            failures++; $display("FAIL hold_issue got req=%b addr=%h exp req=1 addr=108", imem_req, imem_addr);
        end
        mem_auto = 1'b1;
        wait_pc(32'h108, ok);
        checks++; if (!ok || if_id_instr !== word_of(32'h108)) begin
            failures++; $display("FAIL hold_resume got pc=%h i=%h exp pc=108 i=%h", if_id_pc, if_id_instr, word_of(32'h108));
        end
    endtask

    task automatic test_reset_drop();
        bit ok;
        do_reset();
        tick();  // request for RESET_PC granted; response now owed
        rst_n = 1'b0; mem_auto = 1'b0; man_rvalid = 1'b0; man_gnt = 1'b0;
        tick();
        checks++; if (imem_req !== 1'b0) begin
            failures++; $display("FAIL drop_rst_req got=%b exp=0", imem_req);
        end
        rst_n = 1'b1; man_gnt = 1'b1;
        tick();
        man_gnt = 1'b0; man_rvalid = 1'b1; man_rdata = 32'hBAD0_BAD0;
        tick();
        man_rvalid = 1'b0; mem_auto = 1'b1;
        wait_pc(RPC, ok);
        checks++; if (!ok || if_id_instr !== word_of(RPC) || if_id_valid !== 1'b1) begin
            failures++; $display("FAIL drop_first got pc=%h i=%h v=%b exp pc=%h i=%h v=1", if_id_pc, if_id_instr, if_id_valid, RPC, word_of(RPC));
        end
    endtask

    task automatic test_annul();
        bit ok;
        do_reset();
        wait_pc(32'h100, ok);
        wait_pc(32'h104, ok);
        redirect = 1'b1; redirect_annul = 1'b1; redirect_target = 32'h400;
        tick();
        redirect = 1'b0; redirect_annul = 1'b0;
        wait_pc(32'h108, ok);
`ifdef FETCH_ANNUL_EN
        checks++; if (!ok || if_id_valid !== 1'b0 || if_id_instr !== 32'h0 || if_id_npc !== 32'h400) begin
            failures++; $display("FAIL annul_slot got v=%b i=%h npc=%h exp v=0 i=0 npc=400", if_id_valid, if_id_instr, if_id_npc);
        end
`else
        checks++; if (!ok || if_id_valid !== 1'b1 || if_id_instr !== word_of(32'h108) || if_id_npc !== 32'h400) begin
            failures++; $display("FAIL annul_ignored got v=%b i=%h npc=%h exp v=1 i=%h npc=400", if_id_valid, if_id_instr, if_id_npc, word_of(32'h108));
        end
`endif
        wait_pc(32'h400, ok);
        checks++; if (!ok || if_id_valid !== 1'b1 || if_id_instr !== word_of(32'h400)) begin
            failures++; $display("FAIL annul_tgt got pc=%h v=%b i=%h exp pc=400 v=1", if_id_pc, if_id_valid, if_id_instr);
        end
    endtask

    initial begin
        test_reset();
        test_redirect();
        test_same_cycle_redirect();
        test_wrap();
        test_hold();
        test_reset_drop();
        test_annul();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

endmodule
